datamemory_dump: RTL and testbench

Read-out stage downstream of the data memory. On a start pulse (processor halt) it walks data memory addresses 0..CELDAS-1 and streams each word to the UART transmitter as NBITS_D/8 bytes, most significant byte first. While active it owns the memory's read port; its `o_busy` switches the top-level address/Rd mux away from the CPU datapath, which holds Wr low during the dump.

---
 rtl/dump_pkg.sv | 31 +++
 rtl/word_serializer.sv | 74 +++++++
 rtl/datamemory_dump.sv | 131 +++++++++++++
 tb/tb_datamemory_dump.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared definitions for the data-memory dump block.
// - dump_state_e : address FSM state encoding (3 bits)
// - NBITS_D_DEF  : default memory word width
// - NBYTES       : bytes per word for the default width
// - BCNT_W       : byte counter width for the default width
// - dump_nbytes / dump_bcnt_w : the same two values for any word width
package dump_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StLatch = 3'd2,
    StSend  = 3'd3,
    StWait  = 3'd4,
    StNext  = 3'd5,
    StDone  = 3'd6
  } dump_state_e;

  localparam int unsigned NBITS_D_DEF = 16;
  localparam int unsigned NBYTES      = NBITS_D_DEF / 8;
  localparam int unsigned BCNT_W      = $clog2(NBYTES) + 1;

  function automatic int unsigned dump_nbytes(input int unsigned nbits_d);
    return nbits_d / 8;
  endfunction

  function automatic int unsigned dump_bcnt_w(input int unsigned nbits_d);
    return $clog2(nbits_d / 8) + 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits a parallel memory word into bytes, most significant byte first, and
// drives the transmitter start strobe.
// Ports:
//   clk, i_reset    : clock, synchronous active-high reset
//   i_load, i_word  : capture a new word and clear the byte counter
//   i_shift         : current byte accepted; move to the next byte
//   i_send          : the next cycle is a send cycle; present the top byte
//   o_tx_data       : byte to the transmitter, held until the next send
//   o_tx_start      : one-cycle transmit request
//   o_last_byte     : the byte in flight is the last one of the word
module word_serializer
  import dump_pkg::*;
#(
  parameter int unsigned NBITS_D = NBITS_D_DEF,
  parameter int unsigned NBITS_B = 8,
  parameter int unsigned NBytes  = NBYTES,
  parameter int unsigned BcntW   = BCNT_W
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NBITS_D-1:0] i_word,
  input  logic               i_shift,
  input  logic               i_send,
  output logic [NBITS_B-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_last_byte
);

  logic [NBITS_D-1:0] word_q, word_d;
  logic [BcntW-1:0]   bcnt_q, bcnt_d;
  logic [NBITS_B-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;

  always_comb begin
    word_d     = word_q;
    bcnt_d     = bcnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    if (i_load) begin
      word_d = i_word;
      bcnt_d = '0;
    end else if (i_shift) begin
      word_d = word_q << NBITS_B;
      bcnt_d = bcnt_q + BcntW'(1);
    end
    // Take the byte from the next-state word so the freshly loaded word is
    // on the output in the very first send cycle.
    if (i_send) begin
      tx_start_d = 1'b1;
      tx_data_d  = word_d[NBITS_D-1 -: NBITS_B];
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      word_q     <= '0;
      bcnt_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      word_q     <= word_d;
      bcnt_q     <= bcnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  // Counter holds the index of the byte in flight; the last one is NBytes-1.
  assign o_last_byte = (bcnt_q == BcntW'(NBytes - 1));

endmodule

// File: rtl/datamemory_dump.sv
// Streams data memory words 0..CELDAS-1 to the UART transmitter after a start
// pulse, NBITS_D/8 bytes per word, most significant byte first.
// Ports:
//   clk, i_reset   : clock, synchronous active-high reset
//   i_start        : dump request, only honoured while idle
//   o_Rd, o_Add    : memory read strobe and address (owned while busy)
//   i_OutData      : memory read data, valid one cycle after the read
//   o_tx_data      : byte to the transmitter
//   o_tx_start     : one-cycle transmit request
//   i_tx_done      : transmitter finished the current byte
//   o_busy         : dump in progress; steers the external address/Rd mux
//   o_done         : one-cycle pulse after the last byte completes
// All outputs are registered.
module datamemory_dump
  import dump_pkg::*;
#(
  parameter int unsigned NBITS_O = 11,
  parameter int unsigned NBITS_D = NBITS_D_DEF,
  parameter int unsigned CELDAS  = 512,
  parameter int unsigned NBITS_B = 8
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_Rd,
  output logic [NBITS_O-1:0] o_Add,
  input  logic [NBITS_D-1:0] i_OutData,
  output logic [NBITS_B-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned        NBytes   = dump_nbytes(NBITS_D);
  localparam int unsigned        BcntW    = dump_bcnt_w(NBITS_D);
  localparam logic [NBITS_O-1:0] LastAddr = NBITS_O'(CELDAS - 1);

  dump_state_e        state_q, state_d;
  logic [NBITS_O-1:0] addr_q, addr_d;
  logic               rd_q, rd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic load, shift, send, last_byte;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRead;
          addr_d  = '0;
        end
      end
      StRead:  state_d = StLatch;
      StLatch: begin
        load    = 1'b1;
        state_d = StSend;
      end
      StSend:  state_d = StWait;
      StWait: begin
        if (i_tx_done) begin
          shift   = 1'b1;
          state_d = last_byte ? StNext : StSend;
        end
      end
      StNext: begin
        if (addr_q == LastAddr) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + NBITS_O'(1);
          state_d = StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Moore outputs are registered from the next state so they line up with
    // the state they describe.
    rd_d   = (state_d == StRead) || (state_d == StLatch);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    send   = (state_d == StSend);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  word_serializer #(
    .NBITS_D (NBITS_D),
    .NBITS_B (NBITS_B),
    .NBytes  (NBytes),
    .BcntW   (BcntW)
  ) u_serializer (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_load      (load),
    .i_word      (i_OutData),
    .i_shift     (shift),
    .i_send      (send),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_last_byte (last_byte)
  );

  assign o_Rd   = rd_q;
  // The address register only changes on start and in NEXT, so it doubles as
  // the memory address and keeps its last value after the dump.
  assign o_Add  = addr_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_datamemory_dump.sv
// Self-checking bench for datamemory_dump: a memory model, a transmitter
// model with selectable done latency, and an expected byte stream built from
// the memory contents.
module tb_datamemory_dump;

  localparam int unsigned NBITS_O = 11;
  localparam int unsigned NBITS_D = 16;
  localparam int unsigned CELDAS  = 4;
  localparam int unsigned NBITS_B = 8;
  localparam int unsigned NB      = NBITS_D / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_reset = 1'b1;
  logic               start_main = 1'b0;
  logic               start_inj = 1'b0;
  logic               i_tx_done = 1'b0;
  logic               o_Rd, o_tx_start, o_busy, o_done;
  logic [NBITS_O-1:0] o_Add;
  logic [NBITS_D-1:0] rdata = '0;
  logic [NBITS_B-1:0] o_tx_data;

  logic [NBITS_D-1:0] mem [CELDAS];

  datamemory_dump #(
    .NBITS_O (NBITS_O),
    .NBITS_D (NBITS_D),
    .CELDAS  (CELDAS),
    .NBITS_B (NBITS_B)
  ) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_start    (start_main | start_inj),
    .o_Rd       (o_Rd),
    .o_Add      (o_Add),
    .i_OutData  (rdata),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  // Synchronous-read memory: data valid the cycle after the read request.
  always @(posedge clk) begin
    if (o_Rd) rdata <= (o_Add < NBITS_O'(CELDAS)) ? mem[o_Add[1:0]] : 16'hDEAD;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observation state filled by the monitor.
  logic [7:0]         obs_q[$];
  logic [NBITS_O-1:0] add_q[$];
  int                 done_cnt = 0;
  int                 stab_err = 0;
  int unsigned        first_tx_cyc = 0;
  bit                 first_seen = 0;

  // Transmitter model controls: 0 fixed 3, 1 alternate 1/10, 2 random 1..5.
  int mode = 0;
  bit spur = 0;
  bit hold_idle = 0;
  bit inject = 0;

  initial begin : monitor_tx
    bit         pend, watching, prev_rd, alt, dv;
    int         cnt;
    logic [7:0] last_b;
    pend = 0; watching = 0; prev_rd = 0; alt = 0; cnt = 0; last_b = '0;
    forever begin
      @(negedge clk);
      dv = 0;
      start_inj = 1'b0;
      if (i_reset) begin
        pend = 0;
        watching = 0;
      end else begin
        if (o_Rd && !prev_rd) add_q.push_back(o_Add);
        if (o_done) done_cnt++;
        if (o_tx_start) begin
          obs_q.push_back(o_tx_data);
          if (!first_seen) begin
            first_seen = 1;
            first_tx_cyc = cyc;
          end
          last_b = o_tx_data;
          watching = 1;
          pend = 1;
          case (mode)
            0: cnt = 3;
            1: begin cnt = alt ? 10 : 1; alt = ~alt; end
            default: cnt = int'($urandom_range(5, 1));
          endcase
          if (inject && obs_q.size() == 2) start_inj = 1'b1;
        end else begin
          if (watching && o_tx_data != last_b) stab_err++;
          if (pend) begin
            cnt--;
            if (cnt == 0) begin
              dv = 1;
              pend = 0;
            end
          end
        end
      end
      prev_rd = o_Rd;
      i_tx_done = dv | (hold_idle & ~o_busy) | (spur & (o_tx_start | o_Rd));
    end
  end

  task automatic clear_obs();
    obs_q.delete();
    add_q.delete();
    done_cnt = 0;
    stab_err = 0;
    first_seen = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    check(tag, {7'd0, o_Rd, o_Add, o_tx_data, o_tx_start, o_busy, o_done}, 32'd0);
  endtask

  // Runs ndumps dumps (back-to-back starts when ndumps > 1) and compares the
  // observed stream with the one derived from the memory contents.
  task automatic run_dump(input string tag, input int ndumps);
    logic [7:0]  exp_q[$];
    int unsigned t0;
    int          dumps, guard;
    clear_obs();
    for (int d = 0; d < ndumps; d++)
      for (int a = 0; a < int'(CELDAS); a++)
        for (int b = int'(NB) - 1; b >= 0; b--)
          exp_q.push_back(8'((mem[a] >> (8 * b)) & 16'hFF));

    @(negedge clk);
    start_main = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_main = 1'b0;
    check({tag, ".busy_t1"}, {31'd0, o_busy}, 32'd1);
    check({tag, ".rd_t1"}, {31'd0, o_Rd}, 32'd1);
    check({tag, ".add_t1"}, {21'd0, o_Add}, 32'd0);

    dumps = 0;
    guard = 0;
    while (dumps < ndumps && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (o_done) begin
        dumps++;
        @(negedge clk);
        check({tag, ".busy_after_done"}, {31'd0, o_busy}, 32'd0);
        check({tag, ".done_one_cycle"}, {31'd0, o_done}, 32'd0);
        if (dumps < ndumps) begin
          start_main = 1'b1;
          @(negedge clk);
          start_main = 1'b0;
        end
      end
    end
    check({tag, ".dumps_completed"}, dumps, ndumps);
    repeat (5) @(negedge clk);

    check({tag, ".first_tx_latency"}, first_tx_cyc - t0, 32'd3);
    check({tag, ".done_pulses"}, done_cnt, ndumps);
    check({tag, ".busy_end"}, {31'd0, o_busy}, 32'd0);
    check({tag, ".byte_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s.byte%0d", tag, i), {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
    check({tag, ".read_count"}, add_q.size(), ndumps * CELDAS);
    for (int i = 0; i < add_q.size(); i++)
      check($sformatf("%s.addr%0d", tag, i), {21'd0, add_q[i]}, i % CELDAS);
    check({tag, ".tx_data_stable"}, stab_err, 0);
  endtask

  initial begin : main
    int guard;
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    mem[2] = 16'h0000;
    mem[3] = 16'hFFFF;

    // Reset values.
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_outputs");
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    mode = 0;
    run_dump("full", 1);

    mode = 1;
    run_dump("varlat", 1);

    mode = 0;
    inject = 1;
    run_dump("start_busy", 1);
    inject = 0;

    // Reset in the WAIT of the third byte.
    clear_obs();
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    guard = 0;
    while (obs_q.size() < 3 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("midreset.reached_byte3", obs_q.size(), 3);
    @(negedge clk);
    check("midreset.in_wait", {31'd0, o_busy & ~o_tx_start}, 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    check_idle_zero("midreset.outputs_zero");
    @(negedge clk);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    run_dump("after_reset", 1);

    // Spurious done in idle, READ/LATCH and coinciding with start.
    spur = 1;
    hold_idle = 1;
    repeat (4) @(negedge clk);
    check("spur.idle_stays", {31'd0, o_busy}, 32'd0);
    run_dump("spurious", 1);
    spur = 0;
    hold_idle = 0;
    repeat (2) @(negedge clk);

    run_dump("b2b", 2);

    mode = 2;
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < int'(CELDAS); a++) mem[a] = NBITS_D'($urandom);
      run_dump($sformatf("rand%0d", r), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
